// File: rtl/cordic_pkg.sv
// Shared widths, tag type and grant-counter helpers for the CORDIC request arbiter.
package cordic_pkg;

   localparam int DEF_N_REQ     = 4;
   localparam int DEF_XY_W      = 16;
   localparam int DEF_ANGLE_W   = 32;
   localparam int DEF_MAX_OUTST = 8;
   localparam int GRANT_CNT_W   = 16;

   typedef logic [$clog2(DEF_N_REQ)-1:0] tag_t;
   typedef logic [GRANT_CNT_W-1:0]       grant_cnt_t;

   // Counters stick at all-ones instead of wrapping back to zero.
   function automatic grant_cnt_t sat_inc(input grant_cnt_t v);
      return (v == '1) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/cordic_tag_fifo.sv
// In-order tag FIFO recording which requester owns each operation in flight in the rotator.
module cordic_tag_fifo
   import cordic_pkg::*;
#(
   parameter int DEPTH  = DEF_MAX_OUTST,
   parameter int DATA_W = $clog2(DEF_N_REQ)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      push,
   input  logic [DATA_W-1:0]         push_data,
   input  logic                      pop,
   output logic [DATA_W-1:0]         pop_data,
   output logic                      full,
   output logic                      empty,
   output logic [$clog2(DEPTH):0]    count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0]  wp_q, wp_d;
   logic [PTR_W-1:0]  rp_q, rp_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              do_push;
   logic              do_pop;

   assign full     = (cnt_q == CNT_W'(DEPTH));
   assign empty    = (cnt_q == '0);
   assign count    = cnt_q;
   assign pop_data = mem_q[rp_q];
   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;

   // Pointers are PTR_W wide on a power-of-two depth, so they wrap on their own.
   always_comb begin
      mem_d = mem_q;
      wp_d  = wp_q;
      rp_d  = rp_q;
      cnt_d = cnt_q;
      if (do_push) begin
         mem_d[wp_q] = push_data;
         wp_d        = wp_q + 1'b1;
      end
      if (do_pop) begin
         rp_d = rp_q + 1'b1;
      end
      case ({do_push, do_pop})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wp_q  <= '0;
         rp_q  <= '0;
         cnt_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         wp_q  <= wp_d;
         rp_q  <= rp_d;
         cnt_q <= cnt_d;
         mem_q <= mem_d;
      end
   end

endmodule

// File: rtl/cordic_arbiter.sv
// Round-robin arbiter sharing one CORDIC rotator among N_REQ requesters with in-order result routing.
// Optional per-requester grant counters are built when CORDIC_ARB_STATS_EN is defined.
module cordic_arbiter
   import cordic_pkg::*;
#(
   parameter int N_REQ     = DEF_N_REQ,
   parameter int XY_W      = DEF_XY_W,
   parameter int ANGLE_W   = DEF_ANGLE_W,
   parameter int MAX_OUTST = DEF_MAX_OUTST
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [N_REQ-1:0]              req_valid,
   output logic [N_REQ-1:0]              req_ready,
   input  logic [N_REQ*XY_W-1:0]         req_x,
   input  logic [N_REQ*XY_W-1:0]         req_y,
   input  logic [N_REQ*ANGLE_W-1:0]      req_angle,
   output logic [N_REQ-1:0]              rsp_valid,
   input  logic [N_REQ-1:0]              rsp_ready,
   output logic [XY_W-1:0]               rsp_cos,
   output logic [XY_W-1:0]               rsp_sin,
   output logic                          cr_in_valid,
   input  logic                          cr_in_ready,
   output logic [XY_W-1:0]               cr_x,
   output logic [XY_W-1:0]               cr_y,
   output logic [ANGLE_W-1:0]            cr_angle,
   input  logic                          cr_out_valid,
   output logic                          cr_out_ready,
   input  logic [XY_W-1:0]               cr_cos,
   input  logic [XY_W-1:0]               cr_sin,
`ifdef CORDIC_ARB_STATS_EN
   output logic [N_REQ*GRANT_CNT_W-1:0]  grant_cnt,
`endif
   output logic [$clog2(MAX_OUTST):0]    outstanding
);

   localparam int TAG_W = $clog2(N_REQ);
   localparam int CNT_W = $clog2(MAX_OUTST) + 1;

   logic [TAG_W-1:0] rr_ptr_q, rr_ptr_d;
   logic [TAG_W-1:0] win;
   logic             found;
   logic             in_hs;
   logic             out_hs;
   logic             has_head;
   logic [TAG_W-1:0] head_tag;
   logic             fifo_full;
   logic             fifo_empty;
   logic [CNT_W-1:0] fifo_count;

   // Winner: first asserted request at or above rr_ptr, wrapping.
   always_comb begin
      win   = rr_ptr_q;
      found = 1'b0;
      for (int k = 0; k < N_REQ; k++) begin
         if (!found && req_valid[(int'(rr_ptr_q) + k) % N_REQ]) begin
            found = 1'b1;
            win   = TAG_W'((int'(rr_ptr_q) + k) % N_REQ);
         end
      end
   end

   // Issue side; the full flag is registered, so a pop this cycle cannot reopen issue until the next.
   always_comb begin
      cr_in_valid = !rst && found && !fifo_full;
      cr_x        = req_x[int'(win)*XY_W +: XY_W];
      cr_y        = req_y[int'(win)*XY_W +: XY_W];
      cr_angle    = req_angle[int'(win)*ANGLE_W +: ANGLE_W];
      in_hs       = cr_in_valid && cr_in_ready;
      req_ready   = '0;
      for (int i = 0; i < N_REQ; i++) begin
         req_ready[i] = in_hs && (win == TAG_W'(i));
      end
      rr_ptr_d = rr_ptr_q;
      if (in_hs) begin
         rr_ptr_d = (win == TAG_W'(N_REQ - 1)) ? '0 : win + 1'b1;
      end
   end

   // Return side: only the head tag's requester sees the result; everyone behind it waits.
   always_comb begin
      has_head     = !rst && !fifo_empty;
      cr_out_ready = has_head && rsp_ready[head_tag];
      out_hs       = cr_out_valid && cr_out_ready;
      rsp_cos      = cr_cos;
      rsp_sin      = cr_sin;
      rsp_valid    = '0;
      for (int i = 0; i < N_REQ; i++) begin
         rsp_valid[i] = has_head && cr_out_valid && (head_tag == TAG_W'(i));
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr_q <= '0;
      end else begin
         rr_ptr_q <= rr_ptr_d;
      end
   end

   cordic_tag_fifo #(
      .DEPTH  (MAX_OUTST),
      .DATA_W (TAG_W)
   ) u_tag_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (in_hs),
      .push_data (win),
      .pop       (out_hs),
      .pop_data  (head_tag),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   assign outstanding = fifo_count;

`ifdef CORDIC_ARB_STATS_EN
   logic [N_REQ*GRANT_CNT_W-1:0] grant_cnt_q, grant_cnt_d;

   always_comb begin
      grant_cnt_d = grant_cnt_q;
      if (in_hs) begin
         grant_cnt_d[int'(win)*GRANT_CNT_W +: GRANT_CNT_W] =
            sat_inc(grant_cnt_q[int'(win)*GRANT_CNT_W +: GRANT_CNT_W]);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         grant_cnt_q <= '0;
      end else begin
         grant_cnt_q <= grant_cnt_d;
      end
   end

   assign grant_cnt = grant_cnt_q;
`endif

endmodule

// File: tb/tb_cordic_arbiter.sv
// Directed bench for cordic_arbiter with a behavioural in-order rotator and an issue-order scoreboard.
module tb_cordic_arbiter;

   localparam int N = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [N-1:0]  req_valid = '0;
   logic [N-1:0]  req_ready;
   logic [N*16-1:0] req_x, req_y;
   logic [N*32-1:0] req_angle;
   logic [N-1:0]  rsp_valid;
   logic [N-1:0]  rsp_ready = '1;
   logic [15:0]   rsp_cos, rsp_sin;
   logic          cr_in_valid;
   logic          cr_in_ready;
   logic [15:0]   cr_x, cr_y;
   logic [31:0]   cr_angle;
   logic          cr_out_valid;
   logic          cr_out_ready;
   logic [15:0]   cr_cos, cr_sin;
   logic [3:0]    outstanding;
`ifdef CORDIC_ARB_STATS_EN
   logic [N*16-1:0] grant_cnt;
`endif

   logic [15:0] x_drv [N];
   logic [15:0] y_drv [N];
   logic [31:0] a_drv [N];
   logic        rot_ready = 1'b1;

   always #5 clk = ~clk;

   always_comb begin
      req_x = '0;
      req_y = '0;
      req_angle = '0;
      for (int i = 0; i < N; i++) begin
         req_x[i*16 +: 16]     = x_drv[i];
         req_y[i*16 +: 16]     = y_drv[i];
         req_angle[i*32 +: 32] = a_drv[i];
      end
   end

   cordic_arbiter dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_x        (req_x),
      .req_y        (req_y),
      .req_angle    (req_angle),
      .rsp_valid    (rsp_valid),
      .rsp_ready    (rsp_ready),
      .rsp_cos      (rsp_cos),
      .rsp_sin      (rsp_sin),
      .cr_in_valid  (cr_in_valid),
      .cr_in_ready  (cr_in_ready),
      .cr_x         (cr_x),
      .cr_y         (cr_y),
      .cr_angle     (cr_angle),
      .cr_out_valid (cr_out_valid),
      .cr_out_ready (cr_out_ready),
      .cr_cos       (cr_cos),
      .cr_sin       (cr_sin),
`ifdef CORDIC_ARB_STATS_EN
      .grant_cnt    (grant_cnt),
`endif
      .outstanding  (outstanding)
   );

   // Ideal gain-compensated rotation, rounded and clamped to 16-bit signed.
   function automatic logic [15:0] rot_val(input logic [15:0] x, input logic [15:0] y,
                                           input logic [31:0] a, input bit is_sin);
      real th, xr, yr, v;
      int  r;
      th = (real'(a) / 4294967296.0) * 6.283185307179586;
      xr = real'($signed(x));
      yr = real'($signed(y));
      v  = is_sin ? (xr * $sin(th) + yr * $cos(th)) : (xr * $cos(th) - yr * $sin(th));
      r  = $rtoi(v >= 0.0 ? v + 0.5 : v - 0.5);
      if (r > 32767)  r = 32767;
      if (r < -32768) r = -32768;
      return r[15:0];
   endfunction

   // Rotator model: in-order, three-cycle latency, reset with the arbiter.
   logic [15:0] rq_c [16];
   logic [15:0] rq_s [16];
   int unsigned rq_t [16];
   logic [4:0]  rwp, rrp;
   int unsigned cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         rwp <= '0;
         rrp <= '0;
      end else begin
         if (cr_in_valid && cr_in_ready) begin
            rq_c[rwp[3:0]] <= rot_val(cr_x, cr_y, cr_angle, 1'b0);
            rq_s[rwp[3:0]] <= rot_val(cr_x, cr_y, cr_angle, 1'b1);
            rq_t[rwp[3:0]] <= cyc + 3;
            rwp <= rwp + 1'b1;
         end
         if (cr_out_valid && cr_out_ready) rrp <= rrp + 1'b1;
      end
   end

   assign cr_in_ready  = rot_ready;
   assign cr_out_valid = !rst && (rwp != rrp) && (cyc >= rq_t[rrp[3:0]]);
   assign cr_cos       = rq_c[rrp[3:0]];
   assign cr_sin       = rq_s[rrp[3:0]];

   typedef struct {
      int          tag;
      logic [15:0] c;
      logic [15:0] s;
   } exp_t;

   exp_t        sb [$];
   int          grant_log [$];
   int          res_cnt [N];
   int          mptr = 0;
   int          n_grants = 0;
   int          n_cmp = 0;
   int          n_err = 0;
   int          last_tag = -1;
   logic [3:0]  last_rv = '0;
   logic [15:0] last_cos = '0;
   logic [15:0] last_sin = '0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Called at a negedge with inputs settled; checks this cycle and advances one clock.
   task automatic step();
      int         occ;
      int         ew;
      int         head;
      logic [3:0] exp_rr;
      exp_t       e;
      #1;
      occ = sb.size();
      ew  = -1;
      for (int k = 0; k < N; k++) begin
         if (ew < 0 && req_valid[(mptr + k) % N]) ew = (mptr + k) % N;
      end
      exp_rr = (ew >= 0 && occ < 8 && rot_ready) ? 4'(1 << ew) : 4'b0;
      check("req_ready", 32'(req_ready), 32'(exp_rr));
      check("cr_in_valid", 32'(cr_in_valid), 32'(ew >= 0 && occ < 8));
      check("outstanding", 32'(outstanding), 32'(occ));
      if (occ > 0) begin
         head = sb[0].tag;
         check("rsp_valid", 32'(rsp_valid), cr_out_valid ? 32'(1 << head) : 32'd0);
         check("cr_out_ready", 32'(cr_out_ready), 32'(rsp_ready[head]));
      end else begin
         check("rsp_valid_idle", 32'(rsp_valid), 32'd0);
         check("cr_out_ready_idle", 32'(cr_out_ready), 32'd0);
      end
      if (cr_out_valid && cr_out_ready && occ > 0) begin
         e = sb.pop_front();
         check("rsp_cos", 32'(rsp_cos), 32'(e.c));
         check("rsp_sin", 32'(rsp_sin), 32'(e.s));
         res_cnt[e.tag]++;
         last_tag = e.tag;
         last_rv  = rsp_valid;
         last_cos = rsp_cos;
         last_sin = rsp_sin;
      end
      if (cr_in_valid && cr_in_ready && ew >= 0) begin
         e.tag = ew;
         e.c   = rot_val(x_drv[ew], y_drv[ew], a_drv[ew], 1'b0);
         e.s   = rot_val(x_drv[ew], y_drv[ew], a_drv[ew], 1'b1);
         sb.push_back(e);
         grant_log.push_back(ew);
         mptr = (ew + 1) % N;
         n_grants++;
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      check("rst_outstanding", 32'(outstanding), 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_req_ready", 32'(req_ready), 32'd0);
      check("rst_cr_in_valid", 32'(cr_in_valid), 32'd0);
      check("rst_cr_out_ready", 32'(cr_out_ready), 32'd0);
      sb.delete();
      grant_log.delete();
      for (int i = 0; i < N; i++) res_cnt[i] = 0;
      mptr = 0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic run_grants(input int target, input int budget);
      int b = 0;
      while (n_grants < target && b < budget) begin
         step();
         b++;
      end
      check("grant_timeout", 32'(n_grants >= target), 32'd1);
   endtask

   task automatic drain(input int budget);
      int b = 0;
      while (sb.size() > 0 && b < budget) begin
         step();
         b++;
      end
      check("drain_timeout", 32'(sb.size()), 32'd0);
   endtask

   initial begin
      for (int i = 0; i < N; i++) begin
         x_drv[i] = 16'(8000 + 2000 * i);
         y_drv[i] = 16'(1000 * i);
         a_drv[i] = 32'(i) * 32'h2000_0000 + 32'h0100_0000;
      end
      #2;
      @(negedge clk);
      req_valid = 4'b1111;
      do_reset();

      // Single request: 30 deg rotation of (30000, 0).
      req_valid = 4'b0000;
      x_drv[0] = 16'd30000;
      y_drv[0] = 16'd0;
      a_drv[0] = 32'd357913941;
      req_valid = 4'b0001;
      run_grants(n_grants + 1, 20);
      req_valid = 4'b0000;
      drain(30);
      check("single_rsp_valid", 32'(last_rv), 32'h1);
      check("single_cos_range", 32'($signed(last_cos) >= 25680 && $signed(last_cos) <= 26280), 32'd1);
      check("single_sin_range", 32'($signed(last_sin) >= 14700 && $signed(last_sin) <= 15300), 32'd1);
      check("single_outstanding", 32'(outstanding), 32'd0);

      // All four requesting: strict rotation.
      x_drv[0] = 16'd8000;
      y_drv[0] = 16'd0;
      a_drv[0] = 32'h0100_0000;
      do_reset();
      req_valid = 4'b1111;
      run_grants(n_grants + 8, 40);
      req_valid = 4'b0000;
      drain(40);
      for (int k = 0; k < 6; k++) check("rr_order", 32'(grant_log[k]), 32'(k % N));
      for (int i = 0; i < N; i++) check("rr_results", 32'(res_cnt[i]), 32'd2);

      // Results blocked: FIFO fills to 8, issue stalls, then drains in order.
      do_reset();
      rsp_ready = 4'b0000;
      req_valid = 4'b1111;
      run_grants(n_grants + 8, 30);
      for (int k = 0; k < 3; k++) step();
      check("full_req_ready", 32'(req_ready), 32'd0);
      check("full_outstanding", 32'(outstanding), 32'd8);
      rsp_ready = 4'b1111;
      for (int k = 0; k < 6; k++) step();
      req_valid = 4'b0000;
      drain(60);

      // Head-of-line: tag 2 at head with rsp_ready[2]=0 blocks req3's result.
      do_reset();
      rsp_ready = 4'b1011;
      req_valid = 4'b1100;
      run_grants(n_grants + 2, 20);
      req_valid = 4'b0000;
      check("hol_grant_a", 32'(grant_log[0]), 32'd2);
      check("hol_grant_b", 32'(grant_log[1]), 32'd3);
      for (int k = 0; k < 6; k++) step();
      check("hol_cr_out_ready", 32'(cr_out_ready), 32'd0);
      check("hol_rsp_valid", 32'(rsp_valid), 32'b0100);
      check("hol_outstanding", 32'(outstanding), 32'd2);
      rsp_ready = 4'b1111;
      drain(30);
      check("hol_last_tag", 32'(last_tag), 32'd3);

      // Reset with five operations in flight, then normal service.
      do_reset();
      rsp_ready = 4'b0000;
      req_valid = 4'b1111;
      run_grants(n_grants + 5, 20);
      req_valid = 4'b0000;
      step();
      step();
      check("pre_rst_outstanding", 32'(outstanding), 32'd5);
      do_reset();
      rsp_ready = 4'b1111;
      req_valid = 4'b1111;
      run_grants(n_grants + 1, 10);
      req_valid = 4'b0000;
      check("post_rst_first_grant", 32'(grant_log[0]), 32'd0);
      drain(30);
      check("post_rst_outstanding", 32'(outstanding), 32'd0);

`ifdef CORDIC_ARB_STATS_EN
      do_reset();
      check("stats_reset", 32'(grant_cnt[31:16]), 32'd0);
      req_valid = 4'b0010;
      run_grants(n_grants + 70000, 70100);
      req_valid = 4'b0000;
      drain(30);
      grant_log.delete();
      check("stats_cnt0", 32'(grant_cnt[15:0]), 32'd0);
      check("stats_cnt1", 32'(grant_cnt[31:16]), 32'd65535);
      check("stats_cnt2", 32'(grant_cnt[47:32]), 32'd0);
      check("stats_cnt3", 32'(grant_cnt[63:48]), 32'd0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/cordic_arbiter.md
CORDIC_ARBITER -- requirements
Module: cordic_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4: number of requester channels (2..8).
REQ-002 SHALL have parameter XY_W, default 16: operand/result width.
REQ-003 SHALL have parameter ANGLE_W, default 32: binary-angle width (2^ANGLE_W = 360 deg).
REQ-004 SHALL have parameter MAX_OUTST, default 8: tag FIFO depth, power of two.
REQ-005 SHALL have one clock and an asynchronous, active-high reset:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
REQ-006 SHALL have these ports:
- req_valid  in  N_REQ  per-requester request valid.
- req_ready  out  N_REQ  per-requester request accepted.
- req_x, req_y  in  N_REQ*XY_W  packed start vectors, requester i at slice i.
- req_angle  in  N_REQ*ANGLE_W  packed angles.
- rsp_valid  out  N_REQ  result valid for requester i.
- rsp_ready  in  N_REQ  requester i accepts result.
- rsp_cos, rsp_sin  out  XY_W  shared result bus.
- cr_in_valid  out  1  to cordic_rotator in_valid.
- cr_in_ready  in  1  from rotator.
- cr_x, cr_y  out  XY_W  to rotator x_start/y_start.
- cr_angle  out  ANGLE_W  to rotator angle.
- cr_out_valid  in  1  from rotator.
- cr_out_ready  out  1  to rotator.
- cr_cos, cr_sin  in  XY_W  from rotator.
- outstanding  out  $clog2(MAX_OUTST)+1  issued-but-unreturned count.

Function
REQ-007 SHALL select one requester per cycle by round-robin among asserted req_valid, searching upward from rr_ptr and wrapping.
REQ-008 SHALL set cr_in_valid = any req_valid AND tag FIFO not full; cr_x/cr_y/cr_angle = winner's slice, combinational, zero latency.
REQ-009 SHALL assert req_ready[i] only for the winner, and only when cr_in_ready=1 and the FIFO is not full.
REQ-010 SHALL, on a cr_in handshake, push the winner index into the tag FIFO and set rr_ptr = winner+1 mod N_REQ; without a handshake, rr_ptr SHALL hold.
REQ-011 SHALL route results in order; the rotator returns results in issue order. rsp_valid[head_tag] = cr_out_valid when the FIFO is non-empty; all other rsp_valid bits are 0.
REQ-012 SHALL drive cr_out_ready = rsp_ready[head_tag] when the FIFO is non-empty, else 0; rsp_cos/rsp_sin = cr_cos/cr_sin pass-through.
REQ-013 SHALL pop the FIFO on a cr_out handshake; a simultaneous push and pop SHALL leave the occupancy unchanged, with both operations taking effect.
REQ-014 SHALL stall issue when full (outstanding = MAX_OUTST); a pop in the same cycle does not unblock issue until the next cycle.
REQ-015 SHALL wrap the FIFO read/write pointers modulo MAX_OUTST; outstanding equals occupancy.
REQ-016 SHALL hold rsp_valid[i] while rsp_ready[i]=0 and block all later results (head-of-line).

Reset
REQ-017 SHALL, on rst asserted, asynchronously clear rr_ptr=0, the FIFO pointers and outstanding=0; req_ready, rsp_valid, cr_in_valid and cr_out_ready are then 0.
REQ-018 SHALL discard tags for in-flight operations on reset mid-operation; the rotator is reset on the same rst, so no stale results return.

Configuration
REQ-019 SHALL, with macro CORDIC_ARB_STATS_EN defined, add output grant_cnt (N_REQ*16): per-requester 16-bit counters that increment on each cr_in handshake for that requester, saturate at 65535, and reset to 0; without the macro, neither the port nor the counters exist.

Structure
REQ-020 SHALL take the widths, the tag type (logic [$clog2(N_REQ)-1:0]) and the counter width from package cordic_pkg.
REQ-021 SHALL implement the tag FIFO as sub-module cordic_tag_fifo (push/pop/full/empty/count); arbitration stays in cordic_arbiter.

Verification
REQ-022 SHALL test: req0 only, angle 30 deg, x=30000, y=0 -> rsp_valid[0] only; cos 25980+/-300, sin 15000+/-300; outstanding returns to 0.
REQ-023 SHALL test: all four req_valid held high, cr_in_ready=1 -> grant order 0,1,2,3,0,1; each requester gets 2 results.
REQ-024 SHALL test: rsp_ready all 0, continuous requests -> 8 issues, then req_ready all 0 and outstanding=8; release -> drains in issue order.
REQ-025 SHALL test: rsp_ready[2]=0 with tag 2 at head -> cr_out_ready=0 and a later result for req3 is withheld until rsp_ready[2]=1.
REQ-026 SHALL test: rst pulsed with 5 outstanding -> outstanding=0, all rsp_valid=0 and rr_ptr=0 asynchronously; the next request is served normally.
REQ-027 SHALL test, with CORDIC_ARB_STATS_EN: 70000 grants to req1 -> grant_cnt[1]=65535, the others 0.
